bnn_conv_engine: RTL and testbench
==================================

BNN_CONV_ENGINE -- requirements
Module: bnn_conv_engine

Interface
REQ-001 SHALL have parameter IMG_H, default 28, input feature-map height.
REQ-002 SHALL have parameter IMG_W, default 28, input feature-map width.
REQ-003 SHALL have parameter IN_CH, default 1, input channel count.
REQ-004 SHALL have parameter OUT_CH, default 18, filter count.
REQ-005 SHALL have parameter K, default 5, square kernel size.
REQ-006 SHALL have parameter OFF_W, default $clog2(IN_CH*K*K+1), offset width.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port begin_conv, input, 1, start request.
REQ-010 SHALL have port pool_en, input, 1, 2x2 OR-pool mode, sampled with an accepted begin_conv.
REQ-011 SHALL have port image, input, [IMG_H][IMG_W][IN_CH] bits, binary input map.
REQ-012 SHALL have port kernels, input, [OUT_CH][IN_CH][K][K] bits, binary weights.
REQ-013 SHALL have port offset, input, [OUT_CH] x OFF_W, per-filter threshold.
REQ-014 SHALL have port busy, output, 1, high while state is not IDLE.
REQ-015 SHALL have port done_conv, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port out_fmap, output, [OH][OW][OUT_CH] bits; CH=IMG_H-K+1, CW=IMG_W-K+1; OH,OW = CH,CW (pool off) or CH/2,CW/2 (pool on); array sized for pool off.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL accept begin_conv only in IDLE; begin_conv in RUN/DONE SHALL be ignored.
REQ-019 SHALL, in RUN, evaluate one conv position (r,c) per cycle for all OUT_CH filters in parallel.
REQ-020 SHALL compute match = popcount(XNOR(window, kernel)) over IN_CH*K*K bits; bit = (match >= offset[f]), unsigned compare.
REQ-021 SHALL scan pool-off positions row-major, r then c, CH*CW cycles, writing out_fmap[r][c].
REQ-022 SHALL scan pool-on positions by pooled cell row-major, sub-positions (0,0),(0,1),(1,0),(1,1); first sub-position overwrites, next three OR into out_fmap[r/2][c/2]; CH*CW cycles.
REQ-023 SHALL leave out_fmap entries outside OH x OW unchanged in pool-on mode.
REQ-024 SHALL transition RUN -> DONE on the edge writing the last position; done_conv high exactly one cycle (DONE), then IDLE.
REQ-025 SHALL assert done_conv exactly CH*CW cycles after the edge accepting begin_conv.
REQ-026 SHALL hold out_fmap stable from DONE until the next accepted begin_conv.
REQ-027 SHALL require image, kernels, offset stable during RUN; sampling them is combinational per cycle.
REQ-028 SHALL saturate no arithmetic; match range 0..IN_CH*K*K fits OFF_W bits; offset > IN_CH*K*K yields 0.
REQ-029 SHALL reject at elaboration pool_en-capable builds where CH or CW is odd (assertion on parameters).

Reset
REQ-030 SHALL, while rst_n low at a clock edge, force state IDLE, busy 0, done_conv 0, counters 0, out_fmap all 0.
REQ-031 SHALL abort a RUN in progress on reset with no done_conv pulse.
REQ-032 SHALL ignore begin_conv in the same cycle rst_n is low.

Structure
REQ-033 SHALL place FSM state enum and a popcount-width helper function in shared package bnn_pkg.
REQ-034 SHALL use one sub-module bnn_xnor_popcount (window bits, kernel bits, offset -> 1-bit result), instantiated OUT_CH times.
REQ-035 SHALL derive row/column counter widths with $clog2 of CH and CW.

Verification
REQ-036 SHALL test IMG 6x6, IN_CH 2, OUT_CH 3, K 3, all-ones image and kernels, offset 18, pool off -> all 16x3 bits 1, done_conv 16 cycles after start.
REQ-037 SHALL test same with offset 19 -> all bits 0; offset 0 with all-zero kernels -> all bits 1.
REQ-038 SHALL test pool on, single 1 pixel at image[2][2] ch0, kernel filter0 center-only ones ch0, offset 18 -> out_fmap[0][0][0]=1 only, others 0, done after 16 cycles.
REQ-039 SHALL test begin_conv pulsed at cycles 3 and 10 of RUN -> ignored, single done_conv.
REQ-040 SHALL test rst_n low for one cycle at RUN cycle 7 -> busy 0, out_fmap 0, no done_conv; restart completes normally.
REQ-041 SHALL compare default-parameter random image/kernel/offset run against a software XNOR-popcount model, bit-exact.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary conv engine: FSM state encoding and
// width helpers used by the top and the XNOR-popcount slice.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // Bits needed to hold a popcount of n_bits ones (0..n_bits inclusive).
    function automatic int unsigned popcnt_w(input int unsigned n_bits);
        return $clog2(n_bits + 1);
    endfunction

    // Index width for a counter over n positions; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// One filter's binary dot product: popcount(XNOR(window, kernel)) >= offset.
// Ports: window/kernel - N flattened bits in matching order,
//        offset        - unsigned threshold,
//        match_ok_c    - combinational 1-bit result.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned N     = 18,
    parameter int unsigned OFF_W = popcnt_w(N)
) (
    input  logic [N-1:0]     window,
    input  logic [N-1:0]     kernel,
    input  logic [OFF_W-1:0] offset,
    output logic             match_ok_c
);

    localparam int unsigned PC_W  = popcnt_w(N);
    localparam int unsigned CMP_W = (PC_W > OFF_W) ? PC_W : OFF_W;

    logic [PC_W-1:0] match_c;

    // Both operands widened to a common width so an oversized offset simply never matches.
    always_comb begin
        match_c    = PC_W'($countones(~(window ^ kernel)));
        match_ok_c = (CMP_W'(match_c) >= CMP_W'(offset));
    end

endmodule

// File: rtl/bnn_conv_engine.sv
// Binary (XNOR-popcount) convolution engine with optional 2x2 OR pooling.
// Ports: clk/rst_n (sync active-low), begin_conv/pool_en start a job from IDLE,
//        image/kernels/offset are held stable for the whole job,
//        busy (state != IDLE), done_conv (one-cycle pulse), out_fmap result map.
module bnn_conv_engine
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IN_CH  = 1,
    parameter int unsigned OUT_CH = 18,
    parameter int unsigned K      = 5,
    parameter int unsigned OFF_W  = $clog2(IN_CH*K*K+1)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       begin_conv,
    input  logic                                       pool_en,
    input  logic [IMG_H-1:0][IMG_W-1:0][IN_CH-1:0]     image,
    input  logic [OUT_CH-1:0][IN_CH-1:0][K-1:0][K-1:0] kernels,
    input  logic [OUT_CH-1:0][OFF_W-1:0]               offset,
    output logic                                       busy,
    output logic                                       done_conv,
    output logic [IMG_H-K:0][IMG_W-K:0][OUT_CH-1:0]    out_fmap
);

    localparam int unsigned CH     = IMG_H - K + 1;
    localparam int unsigned CW     = IMG_W - K + 1;
    localparam int unsigned PCH    = CH / 2;
    localparam int unsigned PCW    = CW / 2;
    localparam int unsigned N_BITS = IN_CH * K * K;
    localparam int unsigned ROW_W  = idx_w(CH);
    localparam int unsigned COL_W  = idx_w(CW);
    localparam int unsigned IR_W   = idx_w(IMG_H);
    localparam int unsigned IC_W   = idx_w(IMG_W);

    // Pooling walks 2x2 blocks, so the conv map must tile exactly.
    if (((CH % 2) != 0) || ((CW % 2) != 0)) begin : g_odd_conv_dims
        $error("bnn_conv_engine: conv output dimensions must be even for pooling");
    end

    conv_state_e                        state_q, state_d;
    logic [ROW_W-1:0]                   row_q, row_d;
    logic [COL_W-1:0]                   col_q, col_d;
    logic [1:0]                         sub_q, sub_d;
    logic                               pool_q, pool_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [CH-1:0][CW-1:0][OUT_CH-1:0]  fmap_q, fmap_d;

    logic [ROW_W-1:0]                   conv_r_c;
    logic [COL_W-1:0]                   conv_c_c;
    logic [IN_CH-1:0][K-1:0][K-1:0]     win_c;
    logic [OUT_CH-1:0]                  hit_c;
    logic                               last_c;

    // In pool mode row/col count pooled cells; sub picks the quadrant.
    always_comb begin
        if (pool_q) begin
            conv_r_c = ROW_W'({row_q, sub_q[1]});
            conv_c_c = COL_W'({col_q, sub_q[0]});
        end else begin
            conv_r_c = row_q;
            conv_c_c = col_q;
        end
    end

    // Window gather, flattened in the same [ch][i][j] order as the kernels.
    for (genvar i = 0; i < K; i++) begin : g_win_r
        for (genvar j = 0; j < K; j++) begin : g_win_c
            for (genvar ch = 0; ch < IN_CH; ch++) begin : g_win_ch
                assign win_c[ch][i][j] =
                    image[IR_W'(conv_r_c) + IR_W'(i)][IC_W'(conv_c_c) + IC_W'(j)][ch];
            end
        end
    end

    // All filters evaluated in parallel on the same window.
    for (genvar f = 0; f < OUT_CH; f++) begin : g_filter
        bnn_xnor_popcount #(
            .N     (N_BITS),
            .OFF_W (OFF_W)
        ) u_xnor_popcount (
            .window     (win_c),
            .kernel     (kernels[f]),
            .offset     (offset[f]),
            .match_ok_c (hit_c[f])
        );
    end

    // Final scan position for the current mode.
    always_comb begin
        if (pool_q) begin
            last_c = (row_q == ROW_W'(PCH - 1)) && (col_q == COL_W'(PCW - 1)) && (sub_q == 2'd3);
        end else begin
            last_c = (row_q == ROW_W'(CH - 1)) && (col_q == COL_W'(CW - 1));
        end
    end

    // Next-state, scan counters and output-map update.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sub_d   = sub_q;
        pool_d  = pool_q;
        fmap_d  = fmap_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (begin_conv) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    sub_d   = '0;
                    pool_d  = pool_en;
                end
            end
            ST_RUN: begin
                // First quadrant of a pooled cell overwrites, the rest OR in.
                if (pool_q && (sub_q != 2'd0)) begin
                    fmap_d[row_q][col_q] = fmap_q[row_q][col_q] | hit_c;
                end else begin
                    fmap_d[row_q][col_q] = hit_c;
                end
                if (last_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    sub_d   = '0;
                end else if (pool_q) begin
                    sub_d = sub_q + 2'd1;
                    if (sub_q == 2'd3) begin
                        if (col_q == COL_W'(PCW - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end else begin
                    if (col_q == COL_W'(CW - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            sub_q   <= '0;
            pool_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sub_q   <= sub_d;
            pool_q  <= pool_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fmap_q  <= fmap_d;
        end
    end

    assign busy      = busy_q;
    assign done_conv = done_q;
    assign out_fmap  = fmap_q;

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine: a small 6x6/2ch/3-filter/K3 instance for
// hand-computed cases, plus a default-parameter instance checked against a
// software XNOR-popcount model.
module tb_bnn_conv_engine;

    localparam int unsigned S_H = 6, S_W = 6, S_IC = 2, S_OC = 3, S_K = 3, S_OFFW = 5;
    localparam int unsigned S_CH = 4, S_CW = 4;
    localparam int unsigned D_H = 28, D_W = 28, D_IC = 1, D_OC = 18, D_K = 5, D_OFFW = 5;
    localparam int unsigned D_CH = 24, D_CW = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // small instance
    logic                                      begin_s, pool_s, busy_s, done_s;
    logic [S_H-1:0][S_W-1:0][S_IC-1:0]         img_s;
    logic [S_OC-1:0][S_IC-1:0][S_K-1:0][S_K-1:0] ker_s;
    logic [S_OC-1:0][S_OFFW-1:0]               off_s;
    logic [S_CH-1:0][S_CW-1:0][S_OC-1:0]       fmap_s;
    logic [S_CH-1:0][S_CW-1:0][S_OC-1:0]       exp_s;

    // default instance
    logic                                      begin_d, pool_d, busy_d, done_d;
    logic [D_H-1:0][D_W-1:0][D_IC-1:0]         img_d;
    logic [D_OC-1:0][D_IC-1:0][D_K-1:0][D_K-1:0] ker_d;
    logic [D_OC-1:0][D_OFFW-1:0]               off_d;
    logic [D_CH-1:0][D_CW-1:0][D_OC-1:0]       fmap_d;
    logic [D_CH-1:0][D_CW-1:0][D_OC-1:0]       exp_d;

    int n_assert = 0;
    int n_fail   = 0;

    bnn_conv_engine #(
        .IMG_H(S_H), .IMG_W(S_W), .IN_CH(S_IC), .OUT_CH(S_OC), .K(S_K)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .begin_conv (begin_s),
        .pool_en    (pool_s),
        .image      (img_s),
        .kernels    (ker_s),
        .offset     (off_s),
        .busy       (busy_s),
        .done_conv  (done_s),
        .out_fmap   (fmap_s)
    );

    bnn_conv_engine dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .begin_conv (begin_d),
        .pool_en    (pool_d),
        .image      (img_d),
        .kernels    (ker_d),
        .offset     (off_d),
        .busy       (busy_d),
        .done_conv  (done_d),
        .out_fmap   (fmap_d)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a job on the small instance and watch 40 cycles. Pulses of
    // begin_conv at k==pa/pb and a one-cycle reset at k==rst_at are optional.
    task automatic run_small(input logic p, input int pa, input int pb, input int rst_at,
                             output int lat, output int ndone, output logic busy1);
        lat = -1; ndone = 0; busy1 = 1'b0;
        pool_s = p; begin_s = 1'b1;
        @(negedge clk);
        begin_s = 1'b0; pool_s = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            begin_s = 1'b0; rst_n = 1'b1;
            if (done_s) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == 1) busy1 = busy_s;
            if (k == pa || k == pb) begin_s = 1'b1;
            if (k == rst_at) rst_n = 1'b0;
        end
    endtask

    task automatic run_default(input logic p, output int lat);
        lat = -1;
        pool_d = p; begin_d = 1'b1;
        @(negedge clk);
        begin_d = 1'b0; pool_d = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (done_d && lat < 0) lat = k;
        end
    endtask

    function automatic logic conv_bit(input int r, input int c, input int f);
        int m = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                if (img_d[r+i][c+j][0] == ker_d[f][0][i][j]) m++;
        return (m >= int'(off_d[f]));
    endfunction

    int   lat, nd;
    logic b1;

    initial begin
        rst_n = 1'b0; begin_s = 1'b0; pool_s = 1'b0; begin_d = 1'b0; pool_d = 1'b0;
        img_s = '1; ker_s = '1; off_s = {S_OC{5'd18}};
        img_d = '0; ker_d = '0; off_d = '0;
        begin_s = 1'b1;  // must be ignored while in reset
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy_s), 64'd0);
        check("reset_done", 64'(done_s), 64'd0);
        check("reset_fmap", 64'(fmap_s), 64'd0);
        begin_s = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy_s), 64'd0);

        // all ones, offset 18 -> every bit set
        run_small(1'b0, 0, 0, 0, lat, nd, b1);
        exp_s = '1;
        check("ones_latency", 64'(lat), 64'd16);
        check("ones_done_count", 64'(nd), 64'd1);
        check("ones_busy_in_run", 64'(b1), 64'd1);
        check("ones_fmap", 64'(fmap_s), 64'(exp_s));
        check("ones_busy_after", 64'(busy_s), 64'd0);

        // offset one above the maximum match -> all zero
        off_s = {S_OC{5'd19}};
        run_small(1'b0, 0, 0, 0, lat, nd, b1);
        check("off19_latency", 64'(lat), 64'd16);
        check("off19_fmap", 64'(fmap_s), 64'd0);

        // offset 0 always passes
        off_s = '0; ker_s = '0;
        run_small(1'b0, 0, 0, 0, lat, nd, b1);
        check("off0_fmap", 64'(fmap_s), 64'hFFFF_FFFF_FFFF);

        // pooled single pixel; cells outside the 2x2 pooled region keep their ones
        img_s = '0; img_s[2][2][0] = 1'b1;
        ker_s = '1; ker_s[0] = '0; ker_s[0][0][1][1] = 1'b1;
        off_s = {S_OC{5'd18}};
        run_small(1'b1, 0, 0, 0, lat, nd, b1);
        exp_s = '1;
        exp_s[0][0] = 3'b001; exp_s[0][1] = 3'b000;
        exp_s[1][0] = 3'b000; exp_s[1][1] = 3'b000;
        check("pool_latency", 64'(lat), 64'd16);
        check("pool_done_count", 64'(nd), 64'd1);
        check("pool_fmap", 64'(fmap_s), 64'(exp_s));

        // begin_conv during RUN is ignored
        img_s = '1; ker_s = '1; off_s = {S_OC{5'd18}};
        run_small(1'b0, 3, 10, 0, lat, nd, b1);
        check("ignore_latency", 64'(lat), 64'd16);
        check("ignore_done_count", 64'(nd), 64'd1);
        check("ignore_fmap", 64'(fmap_s), 64'hFFFF_FFFF_FFFF);
        check("ignore_busy_after", 64'(busy_s), 64'd0);

        // reset mid-run aborts silently, then a restart completes
        run_small(1'b0, 0, 0, 7, lat, nd, b1);
        check("abort_done_count", 64'(nd), 64'd0);
        check("abort_busy", 64'(busy_s), 64'd0);
        check("abort_fmap", 64'(fmap_s), 64'd0);
        run_small(1'b0, 0, 0, 0, lat, nd, b1);
        check("restart_latency", 64'(lat), 64'd16);
        check("restart_done_count", 64'(nd), 64'd1);
        check("restart_fmap", 64'(fmap_s), 64'hFFFF_FFFF_FFFF);

        // default parameters, random data vs software model
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img_d[r][c][0] = 1'($urandom_range(0, 1));
        for (int f = 0; f < 18; f++) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    ker_d[f][0][i][j] = 1'($urandom_range(0, 1));
            off_d[f] = 5'($urandom_range(9, 16));
        end
        off_d[0] = 5'd26;  // above any possible match
        off_d[1] = 5'd0;   // always passes
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                for (int f = 0; f < 18; f++)
                    exp_d[r][c][f] = conv_bit(r, c, f);
        run_default(1'b0, lat);
        check("rand_latency", 64'(lat), 64'd576);
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                check($sformatf("rand_pix_%0d_%0d", r, c), 64'(fmap_d[r][c]), 64'(exp_d[r][c]));

        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                for (int f = 0; f < 18; f++)
                    exp_d[r][c][f] = conv_bit(2*r, 2*c, f) | conv_bit(2*r, 2*c+1, f) |
                                     conv_bit(2*r+1, 2*c, f) | conv_bit(2*r+1, 2*c+1, f);
        run_default(1'b1, lat);
        check("rand_pool_latency", 64'(lat), 64'd576);
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                check($sformatf("rand_pool_pix_%0d_%0d", r, c), 64'(fmap_d[r][c]), 64'(exp_d[r][c]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
